// File: rtl/mips_mc_control.sv
// Multicycle control sequencer for the MIPS datapath: steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB with a memory handshake, timeout and retire counter.
module mips_mc_control #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             word_we,
   output logic             byte_we,
   output logic             mem_read,
   output logic             byte_load,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       control_type,
   output logic [2:0]       alu_op,
   output logic             alu_src2,
   output logic             rd_src,
   output logic             writeenable,
   output logic             lui,
   output logic             slt,
   output logic             except,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired_count
);

   localparam int unsigned       WAIT_W    = 8;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
      S_MEM   = 3'd3, S_WB     = 3'd4, S_HALT = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      K_BAD, K_ALU, K_SLT, K_LUI, K_LOAD, K_STORE, K_BEQ, K_BNE, K_J, K_JR
   } kind_t;

   state_t            r_state, w_next;
   logic [WAIT_W-1:0] r_wait, w_wait_next, w_wait_inc;
   logic              r_except, w_set_except, w_timeout;
   logic [CNT_W-1:0]  r_count;

   kind_t      w_kind;
   logic [2:0] w_dec_alu;
   logic       w_dec_src2, w_dec_rd, w_is_lbu, w_is_sb;

   logic       w_mem_req, w_word_we, w_byte_we, w_mem_read, w_byte_load;
   logic       w_ir_we, w_pc_we, w_alu_src2, w_rd_src, w_we, w_lui, w_slt;
   logic [1:0] w_ctype;
   logic [2:0] w_alu_op;

   // Instruction class and ALU controls, matching the single-cycle decoder
   always_comb begin
      w_kind     = K_BAD;
      w_dec_alu  = 3'b000;
      w_dec_src2 = 1'b0;
      w_dec_rd   = 1'b0;
      w_is_lbu   = 1'b0;
      w_is_sb    = 1'b0;
      case (opcode)
         6'h00: begin
            case (funct)
               6'h20:   begin w_kind = K_ALU; w_dec_alu = 3'b010; end
               6'h22:   begin w_kind = K_ALU; w_dec_alu = 3'b011; end
               6'h24:   begin w_kind = K_ALU; w_dec_alu = 3'b100; end
               6'h25:   begin w_kind = K_ALU; w_dec_alu = 3'b101; end
               6'h27:   begin w_kind = K_ALU; w_dec_alu = 3'b110; end
               6'h26:   begin w_kind = K_ALU; w_dec_alu = 3'b111; end
               6'h2a:   begin w_kind = K_SLT; w_dec_alu = 3'b011; end
               6'h08:   w_kind = K_JR;
               default: w_kind = K_BAD;
            endcase
         end
         6'h08: begin w_kind = K_ALU;   w_dec_alu = 3'b010; w_dec_src2 = 1'b1; w_dec_rd = 1'b1; end
         6'h0c: begin w_kind = K_ALU;   w_dec_alu = 3'b100; w_dec_src2 = 1'b1; w_dec_rd = 1'b1; end
         6'h0d: begin w_kind = K_ALU;   w_dec_alu = 3'b101; w_dec_src2 = 1'b1; w_dec_rd = 1'b1; end
         6'h0e: begin w_kind = K_ALU;   w_dec_alu = 3'b111; w_dec_src2 = 1'b1; w_dec_rd = 1'b1; end
         6'h0f: begin w_kind = K_LUI;   w_dec_alu = 3'b010; w_dec_src2 = 1'b1; w_dec_rd = 1'b1; end
         6'h23: begin w_kind = K_LOAD;  w_dec_alu = 3'b010; w_dec_src2 = 1'b1; w_dec_rd = 1'b1; end
         6'h24: begin w_kind = K_LOAD;  w_dec_alu = 3'b010; w_dec_src2 = 1'b1; w_dec_rd = 1'b1; w_is_lbu = 1'b1; end
         6'h2b: begin w_kind = K_STORE; w_dec_alu = 3'b010; w_dec_src2 = 1'b1; end
         6'h28: begin w_kind = K_STORE; w_dec_alu = 3'b010; w_dec_src2 = 1'b1; w_is_sb = 1'b1; end
         6'h04: begin w_kind = K_BEQ;   w_dec_alu = 3'b011; end
         6'h05: begin w_kind = K_BNE;   w_dec_alu = 3'b011; end
         6'h02: w_kind = K_J;
         default: w_kind = K_BAD;
      endcase
   end

   assign w_wait_inc = (r_wait == '1) ? r_wait : r_wait + WAIT_W'(1);
   assign w_timeout  = (r_wait >= WAIT_LAST);

   // State, wait counter, sticky exception and retire counter
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state  <= S_FETCH;
         r_wait   <= '0;
         r_except <= 1'b0;
         r_count  <= '0;
      end else begin
         r_state <= w_next;
         r_wait  <= w_wait_next;
         if (w_set_except) r_except <= 1'b1;
         if (w_pc_we)      r_count  <= r_count + CNT_W'(1);
      end
   end

   // Next state and per-state datapath controls; wait counter clears unless stalling
   always_comb begin
      w_next       = r_state;
      w_wait_next  = '0;
      w_set_except = 1'b0;
      w_mem_req    = 1'b0;
      w_word_we    = 1'b0;
      w_byte_we    = 1'b0;
      w_mem_read   = 1'b0;
      w_byte_load  = 1'b0;
      w_ir_we      = 1'b0;
      w_pc_we      = 1'b0;
      w_ctype      = 2'b00;
      w_alu_op     = 3'b000;
      w_alu_src2   = 1'b0;
      w_rd_src     = 1'b0;
      w_we         = 1'b0;
      w_lui        = 1'b0;
      w_slt        = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mem_req  = 1'b1;
            w_mem_read = 1'b1;
            if (mem_ready) begin
               w_ir_we = 1'b1;
               w_next  = S_DECODE;
            end else begin
               w_wait_next = w_wait_inc;
               if (w_timeout) begin
                  w_next       = S_HALT;
                  w_set_except = 1'b1;
               end
            end
         end
         S_DECODE: begin
            if (w_kind == K_BAD) begin
               w_next       = S_HALT;
               w_set_except = 1'b1;
            end else begin
               w_next = S_EXEC;
            end
         end
         S_EXEC: begin
            w_alu_op   = w_dec_alu;
            w_alu_src2 = w_dec_src2;
            w_rd_src   = w_dec_rd;
            case (w_kind)
               K_BEQ:   begin w_pc_we = 1'b1; w_ctype = zero  ? 2'b01 : 2'b00; w_next = S_FETCH; end
               K_BNE:   begin w_pc_we = 1'b1; w_ctype = !zero ? 2'b01 : 2'b00; w_next = S_FETCH; end
               K_J:     begin w_pc_we = 1'b1; w_ctype = 2'b10; w_next = S_FETCH; end
               K_JR:    begin w_pc_we = 1'b1; w_ctype = 2'b11; w_next = S_FETCH; end
               K_LOAD, K_STORE: w_next = S_MEM;
               default: w_next = S_WB;
            endcase
         end
         S_MEM: begin
            w_mem_req   = 1'b1;
            w_mem_read  = (w_kind == K_LOAD);
            w_word_we   = (w_kind == K_STORE) && !w_is_sb;
            w_byte_we   = (w_kind == K_STORE) && w_is_sb;
            w_byte_load = w_is_lbu;
            if (mem_ready) begin
               if (w_kind == K_STORE) begin
                  w_pc_we = 1'b1;
                  w_next  = S_FETCH;
               end else begin
                  w_next = S_WB;
               end
            end else begin
               w_wait_next = w_wait_inc;
               if (w_timeout) begin
                  w_next       = S_HALT;
                  w_set_except = 1'b1;
               end
            end
         end
         S_WB: begin
            w_we        = 1'b1;
            w_pc_we     = 1'b1;
            w_rd_src    = w_dec_rd;
            w_lui       = (w_kind == K_LUI);
            w_slt       = (w_kind == K_SLT);
            w_byte_load = w_is_lbu;
            w_next      = S_FETCH;
         end
         S_HALT:  w_next = S_HALT;
         default: w_next = S_FETCH;
      endcase
   end

   // Every output reads as zero while reset is held low
   assign mem_req       = reset & w_mem_req;
   assign word_we       = reset & w_word_we;
   assign byte_we       = reset & w_byte_we;
   assign mem_read      = reset & w_mem_read;
   assign byte_load     = reset & w_byte_load;
   assign ir_we         = reset & w_ir_we;
   assign pc_we         = reset & w_pc_we;
   assign control_type  = reset ? w_ctype  : 2'b00;
   assign alu_op        = reset ? w_alu_op : 3'b000;
   assign alu_src2      = reset & w_alu_src2;
   assign rd_src        = reset & w_rd_src;
   assign writeenable   = reset & w_we;
   assign lui           = reset & w_lui;
   assign slt           = reset & w_slt;
   assign except        = reset & r_except;
   assign state         = reset ? 3'(r_state) : 3'd0;
   assign retired_count = reset ? r_count : '0;

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomized scoreboard bench for mips_mc_control: the driver expands each
// instruction into expected per-cycle outputs, a negedge monitor compares them.
module tb_mips_mc_control;

   localparam int unsigned TO = 4;
   localparam int unsigned CW = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [5:0]    opcode = 6'h0, funct = 6'h0;
   logic          zero = 1'b0, mem_ready = 1'b0;
   logic          mem_req, word_we, byte_we, mem_read, byte_load, ir_we, pc_we;
   logic [1:0]    control_type;
   logic [2:0]    alu_op;
   logic          alu_src2, rd_src, writeenable, lui, slt, except;
   logic [2:0]    state;
   logic [CW-1:0] retired_count;

   mips_mc_control #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .word_we(word_we), .byte_we(byte_we),
      .mem_read(mem_read), .byte_load(byte_load), .ir_we(ir_we), .pc_we(pc_we),
      .control_type(control_type), .alu_op(alu_op), .alu_src2(alu_src2), .rd_src(rd_src),
      .writeenable(writeenable), .lui(lui), .slt(slt), .except(except), .state(state),
      .retired_count(retired_count));

   always #5 clock = ~clock;

   typedef struct {
      logic [2:0] st;
      logic mem_req, mem_read, word_we, byte_we, byte_load, ir_we, pc_we;
      logic [1:0] ctype;
      logic chk_alu;
      logic [2:0] alu_op;
      logic alu_src2;
      logic chk_rd, rd_src;
      logic we, lui, slt, exc;
      logic [CW-1:0] cnt;
   } exp_t;

   localparam int KBAD = 0, KALU = 1, KLD = 2, KST = 3, KBEQ = 4, KBNE = 5, KJ = 6, KJR = 7;

   typedef struct {
      int kind;
      logic [2:0] alu;
      logic chk_alu, src2, rd, lbu, sb, is_lui, is_slt;
   } info_t;

   exp_t          exp_q[$];
   int            n_chk = 0, n_pass = 0;
   logic [CW-1:0] m_cnt = '0;

   logic [11:0] tbl [20] = '{12'h020, 12'h022, 12'h024, 12'h025, 12'h027, 12'h026,
                             12'h02a, 12'h008, 12'h200, 12'h300, 12'h340, 12'h380,
                             12'h3c0, 12'h8c0, 12'h900, 12'hac0, 12'ha00, 12'h100,
                             12'h140, 12'h080};

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] r6();
      return 6'($urandom);
   endfunction

   // ISA table: instruction class and the ALU settings expected in EXEC
   function automatic info_t decode_ref(input logic [5:0] op, input logic [5:0] fn);
      info_t d;
      d.kind = KBAD; d.alu = 3'b000; d.chk_alu = 1'b1; d.src2 = 1'b0; d.rd = 1'b0;
      d.lbu = 1'b0; d.sb = 1'b0; d.is_lui = 1'b0; d.is_slt = 1'b0;
      case (op)
         6'h00: case (fn)
            6'h20: begin d.kind = KALU; d.alu = 3'b010; end
            6'h22: begin d.kind = KALU; d.alu = 3'b011; end
            6'h24: begin d.kind = KALU; d.alu = 3'b100; end
            6'h25: begin d.kind = KALU; d.alu = 3'b101; end
            6'h27: begin d.kind = KALU; d.alu = 3'b110; end
            6'h26: begin d.kind = KALU; d.alu = 3'b111; end
            6'h2a: begin d.kind = KALU; d.alu = 3'b011; d.is_slt = 1'b1; end
            6'h08: begin d.kind = KJR;  d.chk_alu = 1'b0; end
            default: d.kind = KBAD;
         endcase
         6'h08: begin d.kind = KALU; d.alu = 3'b010; d.src2 = 1'b1; d.rd = 1'b1; end
         6'h0c: begin d.kind = KALU; d.alu = 3'b100; d.src2 = 1'b1; d.rd = 1'b1; end
         6'h0d: begin d.kind = KALU; d.alu = 3'b101; d.src2 = 1'b1; d.rd = 1'b1; end
         6'h0e: begin d.kind = KALU; d.alu = 3'b111; d.src2 = 1'b1; d.rd = 1'b1; end
         6'h0f: begin d.kind = KALU; d.chk_alu = 1'b0; d.rd = 1'b1; d.is_lui = 1'b1; end
         6'h23: begin d.kind = KLD; d.alu = 3'b010; d.src2 = 1'b1; d.rd = 1'b1; end
         6'h24: begin d.kind = KLD; d.alu = 3'b010; d.src2 = 1'b1; d.rd = 1'b1; d.lbu = 1'b1; end
         6'h2b: begin d.kind = KST; d.alu = 3'b010; d.src2 = 1'b1; end
         6'h28: begin d.kind = KST; d.alu = 3'b010; d.src2 = 1'b1; d.sb = 1'b1; end
         6'h04: begin d.kind = KBEQ; d.alu = 3'b011; end
         6'h05: begin d.kind = KBNE; d.alu = 3'b011; end
         6'h02: begin d.kind = KJ; d.chk_alu = 1'b0; end
         default: d.kind = KBAD;
      endcase
      return d;
   endfunction

   function automatic exp_t mk(input logic [2:0] st);
      exp_t e;
      e.st = st; e.mem_req = 0; e.mem_read = 0; e.word_we = 0; e.byte_we = 0;
      e.byte_load = 0; e.ir_we = 0; e.pc_we = 0; e.ctype = 2'b00; e.chk_alu = 0;
      e.alu_op = 3'b000; e.alu_src2 = 0; e.chk_rd = 0; e.rd_src = 0; e.we = 0;
      e.lui = 0; e.slt = 0; e.exc = 0; e.cnt = m_cnt;
      return e;
   endfunction

   task automatic drive(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy, input exp_t e);
      @(posedge clock);
      #1;
      reset = rst; opcode = op; funct = fn; zero = z; mem_ready = rdy;
      exp_q.push_back(e);
   endtask

   task automatic do_reset(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e = mk(3'd0);
         e.cnt = '0;
         drive(1'b0, r6(), r6(), rb(), rb(), e);
      end
      m_cnt = '0;
   endtask

   task automatic halt_seq();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         e = mk(3'd5);
         e.exc = 1'b1;
         drive(1'b1, r6(), r6(), rb(), rb(), e);
      end
      do_reset(1 + int'($urandom_range(0, 1)));
   endtask

   function automatic exp_t mem_exp(input info_t d);
      exp_t e;
      e = mk(3'd3);
      e.mem_req   = 1'b1;
      e.mem_read  = (d.kind == KLD);
      e.word_we   = (d.kind == KST) && !d.sb;
      e.byte_we   = (d.kind == KST) && d.sb;
      e.byte_load = d.lbu;
      return e;
   endfunction

   // One instruction: fw/mw = not-ready cycles in FETCH/MEM; abort resets in MEM
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fw, input int mw, input bit abort);
      info_t d;
      exp_t  e;
      d = decode_ref(op, fn);
      for (int i = 0; i < fw && i < int'(TO); i++) begin
         e = mk(3'd0); e.mem_req = 1'b1; e.mem_read = 1'b1;
         drive(1'b1, r6(), r6(), rb(), 1'b0, e);
      end
      if (fw >= int'(TO)) begin halt_seq(); return; end
      e = mk(3'd0); e.mem_req = 1'b1; e.mem_read = 1'b1; e.ir_we = 1'b1;
      drive(1'b1, r6(), r6(), rb(), 1'b1, e);
      e = mk(3'd1);
      drive(1'b1, op, fn, rb(), rb(), e);
      if (d.kind == KBAD) begin halt_seq(); return; end
      e = mk(3'd2); e.chk_alu = d.chk_alu; e.alu_op = d.alu; e.alu_src2 = d.src2;
      case (d.kind)
         KBEQ: begin e.pc_we = 1'b1; e.ctype = z  ? 2'b01 : 2'b00; end
         KBNE: begin e.pc_we = 1'b1; e.ctype = !z ? 2'b01 : 2'b00; end
         KJ:   begin e.pc_we = 1'b1; e.ctype = 2'b10; end
         KJR:  begin e.pc_we = 1'b1; e.ctype = 2'b11; end
         default: ;
      endcase
      drive(1'b1, op, fn, z, rb(), e);
      if (e.pc_we) begin m_cnt = m_cnt + 1'b1; return; end
      if (d.kind == KLD || d.kind == KST) begin
         if (abort) begin do_reset(1); return; end
         for (int i = 0; i < mw && i < int'(TO); i++) begin
            e = mem_exp(d);
            drive(1'b1, op, fn, rb(), 1'b0, e);
         end
         if (mw >= int'(TO)) begin halt_seq(); return; end
         e = mem_exp(d);
         if (d.kind == KST) e.pc_we = 1'b1;
         drive(1'b1, op, fn, rb(), 1'b1, e);
         if (d.kind == KST) begin m_cnt = m_cnt + 1'b1; return; end
      end
      e = mk(3'd4); e.we = 1'b1; e.pc_we = 1'b1; e.chk_rd = 1'b1; e.rd_src = d.rd;
      e.lui = d.is_lui; e.slt = d.is_slt; e.byte_load = d.lbu;
      drive(1'b1, op, fn, rb(), rb(), e);
      m_cnt = m_cnt + 1'b1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
   endtask

   // Monitor: one expected record per clock cycle, sampled mid-cycle
   always @(negedge clock) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("state", 32'(state), 32'(e.st));
         chk("mem_req", 32'(mem_req), 32'(e.mem_req));
         chk("mem_read", 32'(mem_read), 32'(e.mem_read));
         chk("word_we", 32'(word_we), 32'(e.word_we));
         chk("byte_we", 32'(byte_we), 32'(e.byte_we));
         chk("byte_load", 32'(byte_load), 32'(e.byte_load));
         chk("ir_we", 32'(ir_we), 32'(e.ir_we));
         chk("pc_we", 32'(pc_we), 32'(e.pc_we));
         chk("writeenable", 32'(writeenable), 32'(e.we));
         chk("lui", 32'(lui), 32'(e.lui));
         chk("slt", 32'(slt), 32'(e.slt));
         chk("except", 32'(except), 32'(e.exc));
         chk("retired_count", 32'(retired_count), 32'(e.cnt));
         if (e.pc_we)   chk("control_type", 32'(control_type), 32'(e.ctype));
         if (e.chk_alu) begin
            chk("alu_op", 32'(alu_op), 32'(e.alu_op));
            chk("alu_src2", 32'(alu_src2), 32'(e.alu_src2));
         end
         if (e.chk_rd)  chk("rd_src", 32'(rd_src), 32'(e.rd_src));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] ent;
      logic [5:0]  op, fn;
      int          fw, mw;
      do_reset(2);
      run_instr(6'h0e, r6(), 1'b0, 0, 0, 0);    // XORI
      run_instr(6'h04, r6(), 1'b1, 0, 0, 0);    // BEQ taken
      run_instr(6'h05, r6(), 1'b1, 0, 0, 0);    // BNE not taken
      run_instr(6'h23, r6(), 1'b0, 0, 3, 0);    // LW with 3 wait cycles
      run_instr(6'h28, r6(), 1'b0, 0, 0, 0);    // SB
      run_instr(6'h24, r6(), 1'b0, 2, 1, 0);    // LBU
      run_instr(6'h00, 6'h20, 1'b0, TO - 1, 0, 0);
      run_instr(6'h02, r6(), 1'b0, TO, 0, 0);   // FETCH timeout
      run_instr(6'h2b, r6(), 1'b0, 0, TO, 0);   // MEM timeout
      run_instr(6'h3f, r6(), 1'b0, 0, 0, 0);    // bad opcode
      run_instr(6'h00, 6'h01, 1'b0, 0, 0, 0);   // bad funct
      run_instr(6'h2b, r6(), 1'b0, 0, 0, 1);    // reset during SW MEM
      run_instr(6'h00, 6'h2a, 1'b0, 0, 0, 0);   // SLT
      run_instr(6'h0f, r6(), 1'b0, 0, 0, 0);    // LUI
      run_instr(6'h00, 6'h08, 1'b0, 0, 0, 0);   // JR
      for (int i = 0; i < 20; i++) run_instr(6'h02, r6(), rb(), 0, 0, 0);
      for (int i = 0; i < 300; i++) begin
         ent = tbl[$urandom_range(0, 19)];
         op  = ent[11:6];
         fn  = (op == 6'h00) ? ent[5:0] : r6();
         if ($urandom_range(0, 15) == 0) begin
            if (rb()) op = 6'h3f; else begin op = 6'h00; fn = 6'h01; end
         end
         fw = ($urandom_range(0, 15) == 0) ? int'(TO) + int'($urandom_range(0, 1))
                                           : int'($urandom_range(0, TO - 1));
         mw = ($urandom_range(0, 15) == 0) ? int'(TO) : int'($urandom_range(0, TO - 1));
         run_instr(op, fn, rb(), fw, mw, ($urandom_range(0, 31) == 0));
      end
      @(negedge clock);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
